// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: operation codes (also used by the
// ALU control decoder) and FSM state encodings.
package seq_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative one-bit-per-cycle shifter: accumulator, down-counter and
// direction latch. 'load' captures the operand, amount and direction,
// 'step' shifts once and decrements, 'last' flags the final step.
// 'shifted' is the accumulator after one more shift, so the caller can
// capture the finished value on the same edge as the last step.
module seq_alu_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] amount,
  input  logic                   right,
  output logic [DATA_WIDTH-1:0]  shifted,
  output logic                   last
);

  logic [DATA_WIDTH-1:0]  acc;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   dir_right;

  // One-bit shift of the accumulator in the latched direction (zero fill).
  always_comb begin
    shifted = '0;
    if (dir_right) shifted = {1'b0, acc[DATA_WIDTH-1:1]};
    else           shifted = {acc[DATA_WIDTH-2:0], 1'b0};
  end

  assign last = (count == SHAMT_WIDTH'(1));

  // Accumulator, counter and direction latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      count     <= '0;
      dir_right <= 1'b0;
    end else if (load) begin
      acc       <= data;
      count     <= amount;
      dir_right <= right;
    end else if (step) begin
      acc       <= shifted;
      count     <= count - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with start/done handshake. ADD/OR/SUB finish in one cycle;
// SLL/SRL iterate one bit per cycle through seq_alu_shifter.
// Build option: define SEQ_ALU_BARREL_SHIFT_EN to replace the iterative
// shifter with a single-cycle barrel shifter (busy_o then tied low).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  alu_value;
  logic [DATA_WIDTH-1:0]  result_next;
  logic                   done_next;
  logic [DATA_WIDTH-1:0]  result;
  logic                   zero;
  logic                   done;

  assign shamt = b_i[SHAMT_WIDTH-1:0];

  // Single-cycle datapath. In the iterative build this only sees shifts
  // with a zero amount, which pass operand A through unchanged.
  always_comb begin
    alu_value = '0;
    case (alu_operation_i)
      ALU_ADD: alu_value = a_i + b_i;
      ALU_OR:  alu_value = a_i | b_i;
      ALU_SUB: alu_value = a_i - b_i;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
      ALU_SLL: alu_value = a_i << shamt;
      ALU_SRL: alu_value = a_i >> shamt;
`else
      ALU_SLL: alu_value = a_i;
      ALU_SRL: alu_value = a_i;
`endif
      default: alu_value = '0;
    endcase
  end

`ifdef SEQ_ALU_BARREL_SHIFT_EN

  // Every accepted request completes at the edge that samples it.
  always_comb begin
    done_next   = start_i;
    result_next = alu_value;
  end

  assign busy_o = 1'b0;

`else

  state_t                state;
  state_t                state_next;
  logic                  load;
  logic                  step;
  logic                  shift_req;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  last;

  assign shift_req = is_shift(alu_operation_i) && (shamt != '0);

  seq_alu_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .data    (a_i),
    .amount  (shamt),
    .right   (alu_operation_i == ALU_SRL),
    .shifted (shifted),
    .last    (last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state, shifter control and completion; start_i is ignored in SHIFT.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    step        = 1'b0;
    done_next   = 1'b0;
    result_next = '0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (shift_req) begin
            load       = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            done_next   = 1'b1;
            result_next = alu_value;
          end
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (last) begin
          state_next  = ST_IDLE;
          done_next   = 1'b1;
          result_next = shifted;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state == ST_SHIFT);

`endif

  // Output registers: result/zero only move on the completing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= done_next;
      if (done_next) begin
        result <= result_next;
        zero   <= (result_next == '0);
      end
    end
  end

  assign result_o = result;
  assign zero_o   = zero;
  assign done_o   = done;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver predicts each accepted request's
// result and completion edge; the monitor compares when done_o appears.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;

  seq_alu #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          edge_no;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          free_edge = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] last_res = '0;
  logic        end_req = 1'b0;
  logic        final_done = 1'b0;

  // Reference: what the operation means, not how the RTL computes it.
  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a | b;
      4'd2:    return a << sh;
      4'd3:    return a >> sh;
      4'd4:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // Extra edges between acceptance and completion.
  function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    return 0;
`else
    if ((op == 4'd2 || op == 4'd3) && (b % 32) != 0) return int'(b % 32);
    return 0;
`endif
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    logic exp_busy;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!reset) begin
        q.delete();
        last_res = '0;
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
      end else begin
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("busy", 32'(busy_o), 32'(exp_busy));
        if (done_o) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done_o), 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_edge", 32'(cyc), 32'(e.edge_no));
            last_res = e.res;
          end
        end else if (q.size() > 0 && q[0].edge_no <= cyc) begin
          e = q.pop_front();
          chk("missing_done", 32'(done_o), 32'd1);
          last_res = e.res;
        end
      end
      chk("result", result_o, last_res);
      chk("zero", 32'(zero_o), 32'(last_res == 32'd0));
      if (end_req && !final_done) begin
        chk("leftover", 32'(q.size()), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   p;
    int   n;
    exp_t e;
    @(negedge clk);
    start_i         = 1'b1;
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    p = cyc + 1;
    if (p > free_edge) begin
      n         = model_latency(op, b);
      e.res     = model_result(op, a, b);
      e.edge_no = p + n;
      q.push_back(e);
      free_edge = p + n;
      if (n > 0) begin
        busy_lo = p;
        busy_hi = p + n - 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start_i         = 1'b0;
    alu_operation_i = 4'($urandom);
    a_i             = $urandom;
    b_i             = $urandom;
  endtask

  task automatic wait_free();
    idle();
    while (cyc < free_edge) idle();
  endtask

  // Driver: directed cases, then randomized traffic.
  initial begin
    logic [3:0]  op;
    logic [31:0] b;
    reset = 1'b0;
    start_i = 1'b0;
    alu_operation_i = '0;
    a_i = '0;
    b_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    free_edge = cyc;
    idle();

    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    wait_free();
    issue(4'd4, 32'd5, 32'd7);
    wait_free();
    issue(4'd2, 32'h1, 32'd31);
    wait_free();
    issue(4'd3, 32'h8000_0000, 32'h24);
    wait_free();
    issue(4'd2, 32'h1234, 32'd0);
    wait_free();

    issue(4'd2, 32'h0000_00A5, 32'd8);
    for (int i = 0; i < 10; i++) issue(4'd0, 32'd100, 32'd23);
    issue(4'd1, 32'hF0, 32'h0F);
    issue(4'd0, 32'd7, 32'd9);
    wait_free();

    issue(4'd7, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_free();
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    issue(4'd3, 32'hFFFF_FFFF, 32'd31);
    wait_free();
`endif

    issue(4'd2, 32'h1, 32'd20);
    repeat (5) idle();
    @(negedge clk);
    reset   = 1'b0;
    start_i = 1'b0;
    busy_lo = 1;
    busy_hi = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    free_edge = cyc;
    repeat (3) idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 9))
          0:       op = 4'd0;
          1:       op = 4'd1;
          2, 5:    op = 4'd2;
          3, 6:    op = 4'd3;
          4:       op = 4'd4;
          default: op = 4'($urandom_range(5, 15));
        endcase
        b = $urandom;
        if ($urandom_range(0, 3) == 0) b[4:0] = 5'($urandom_range(0, 3));
        issue(op, $urandom, b);
      end else begin
        idle();
      end
    end

    wait_free();
    repeat (3) idle();
    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
